mdu_hilo: RTL



---
 rtl/mdu_hilo.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo: E-stage multiply/divide unit owning the HI/LO registers.
//
// Runs mult/multu/div/divu as fixed-latency multi-cycle operations. The result
// is computed at the issue edge, held in a pending register, and committed to
// HI/LO at the end of the busy period. mfhi/mflo reads and mthi/mtlo writes
// are served directly.
//
// Optional feature: define MDU_MADD_EN to add madd (8) / maddu (9), which
// accumulate A*B into {HI,LO} with a MULT_CYCLES latency.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu/madd/maddu (>=1)
//   DIV_CYCLES   busy cycles for div/divu (>=1)
// Ports:
//   clk      in   1   system clock, rising edge
//   reset    in   1   asynchronous active-high reset, clears all state
//   req      in   1   E-stage instruction valid
//   MDUType  in   5   command code (mfhi=0 mflo=1 mthi=2 mtlo=3 mult=4
//                     multu=5 div=6 divu=7 [madd=8 maddu=9]; 31=none)
//   A        in   32  rs operand
//   B        in   32  rt operand
//   start    out  1   combinational issue strobe to the hazard unit
//   busy     out  1   registered, high while an operation is in flight
//   MDUO     out  32  mfhi/mflo read data, 0 otherwise
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [4:0]  MDUType,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] MDUO
);

  typedef enum logic [4:0] {
    CMD_MFHI  = 5'd0,
    CMD_MFLO  = 5'd1,
    CMD_MTHI  = 5'd2,
    CMD_MTLO  = 5'd3,
    CMD_MULT  = 5'd4,
    CMD_MULTU = 5'd5,
    CMD_DIV   = 5'd6,
    CMD_DIVU  = 5'd7,
    CMD_MADD  = 5'd8,
    CMD_MADDU = 5'd9
  } cmd_t;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [31:0]    hi;
  logic [31:0]    lo;
  logic [31:0]    p_hi;
  logic [31:0]    p_lo;
  logic           p_wr;

  // Command decode
  logic is_mul;
  logic is_div;
  logic is_madd;
  logic is_md;

  always_comb begin
    is_mul  = (MDUType == CMD_MULT) || (MDUType == CMD_MULTU);
    is_div  = (MDUType == CMD_DIV)  || (MDUType == CMD_DIVU);
`ifdef MDU_MADD_EN
    is_madd = (MDUType == CMD_MADD) || (MDUType == CMD_MADDU);
`else
    is_madd = 1'b0;
`endif
    is_md   = is_mul | is_div | is_madd;
  end

  assign busy  = (state == BUSY);
  assign start = req & is_md & ~busy & ~reset;

  // Multiplier: low 64 bits of the 64x64 product of the extended operands
  // equal the true signed/unsigned 32x32 product.
  logic [63:0] a_sx;
  logic [63:0] b_sx;
  logic [63:0] a_zx;
  logic [63:0] b_zx;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  always_comb begin
    a_sx   = {{32{A[31]}}, A};
    b_sx   = {{32{B[31]}}, B};
    a_zx   = {32'd0, A};
    b_zx   = {32'd0, B};
    prod_s = a_sx * b_sx;
    prod_u = a_zx * b_zx;
  end

  // Divider: one unsigned divider on magnitudes, signs restored afterwards.
  // Working on magnitudes keeps 0x80000000 / -1 well defined (wraps to
  // 0x80000000, remainder 0). A zero divisor is replaced by 1 so the datapath
  // never carries X; the result is discarded in that case anyway.
  logic        div_signed;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] dvs_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    div_signed = (MDUType == CMD_DIV);
    dvd        = (div_signed && A[31]) ? (~A + 32'd1) : A;
    dvs        = (div_signed && B[31]) ? (~B + 32'd1) : B;
    dvs_safe   = (dvs == '0) ? 32'd1 : dvs;
    q_mag      = dvd / dvs_safe;
    r_mag      = dvd % dvs_safe;
    quo        = (div_signed && (A[31] ^ B[31])) ? (~q_mag + 32'd1) : q_mag;
    rem        = (div_signed && A[31]) ? (~r_mag + 32'd1) : r_mag;
  end

  // Result selection for the issue edge
  logic [63:0]   res;
  logic          res_wr;
  logic [CW-1:0] load_cnt;

  always_comb begin
    res      = '0;
    res_wr   = 1'b1;
    load_cnt = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    case (MDUType)
      CMD_MULT:  res = prod_s;
      CMD_MULTU: res = prod_u;
      CMD_DIV,
      CMD_DIVU: begin
        res    = {rem, quo};
        res_wr = (B != '0);
      end
`ifdef MDU_MADD_EN
      CMD_MADD:  res = {hi, lo} + prod_s;
      CMD_MADDU: res = {hi, lo} + prod_u;
`endif
      default:   res = '0;
    endcase
  end

  // Control FSM and HI/LO state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      p_wr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            p_hi  <= res[63:32];
            p_lo  <= res[31:0];
            p_wr  <= res_wr;
            cnt   <= load_cnt;
            state <= BUSY;
          end else if (req && (MDUType == CMD_MTHI)) begin
            hi <= A;
          end else if (req && (MDUType == CMD_MTLO)) begin
            lo <= A;
          end
        end
        BUSY: begin
          if (cnt == CW'(1)) begin
            if (p_wr) begin
              hi <= p_hi;
              lo <= p_lo;
            end
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Read port
  always_comb begin
    MDUO = '0;
    if (req && (MDUType == CMD_MFHI)) begin
      MDUO = hi;
    end else if (req && (MDUType == CMD_MFLO)) begin
      MDUO = lo;
    end
  end

endmodule
